// File: rtl/example_fsm.sv
// Moore sequence detector for the serial pattern 1,1,0,1 (overlapping occurrences allowed).
// y is high for the single state that follows a completed pattern.
module example_fsm (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S11   = 3'd2,
        S110  = 3'd3,
        S1101 = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Each state is the longest received suffix that is also a prefix of 1101.
    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = x ? S1    : S0;
            S1:      state_next = x ? S11   : S0;
            S11:     state_next = x ? S11   : S110;
            S110:    state_next = x ? S1101 : S0;
            S1101:   state_next = x ? S11   : S0;
            default: state_next = S0;
        endcase
    end

    always_comb begin
        y = 1'b0;
        if (state == S1101) begin
            y = 1'b1;
        end
    end

endmodule

// File: tb/tb_example_fsm.sv
// Self-checking bench for example_fsm: directed scenarios followed by random bits
// and random asynchronous reset pulses, compared against a bit-history model.
module tb_example_fsm;

    logic clk;
    logic reset;
    logic x;
    logic y;

    int checks;
    int errors;

    // Reference model: the bits received since the last reset.
    logic [3:0] hist;
    int         nbits;

    example_fsm dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_y();
        return (nbits >= 4) && (hist == 4'b1101);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        hist  = 4'b0000;
        nbits = 0;
    endtask

    // Drive one bit, let the DUT sample it, then check y shortly after the edge.
    task automatic step(input logic b, input string tag);
        x = b;
        @(posedge clk);
        hist  = {hist[2:0], b};
        nbits = nbits + 1;
        #1;
        chk(tag, y, model_y());
    endtask

    task automatic step_exp(input logic b, input logic expv, input string tag);
        step(b, tag);
        chk({tag, "_dir"}, y, expv);
    endtask

    // Reset pulse placed strictly between rising edges; called at posedge+1.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b1;
        #1 chk(tag, y, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        reset = 1'b1;
        x     = 1'bx;

        // Reset held across edges with x undriven.
        #1 chk("rst_async", y, 1'b0);
        @(posedge clk); #1 chk("rst_hold1", y, 1'b0);
        @(posedge clk); #1 chk("rst_hold2", y, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        x     = 1'b0;
        for (int i = 0; i < 10; i++) step_exp(1'b0, 1'b0, "zeros");

        // Single detection.
        mid_reset("rst_a");
        step_exp(1'b1, 1'b0, "single_e1");
        step_exp(1'b1, 1'b0, "single_e2");
        step_exp(1'b0, 1'b0, "single_e3");
        step_exp(1'b1, 1'b1, "single_e4");
        step_exp(1'b0, 1'b0, "single_e5");
        step_exp(1'b0, 1'b0, "single_e6");

        // Overlap: 1101101 -> pulses after edges 4 and 7.
        mid_reset("rst_b");
        step_exp(1'b1, 1'b0, "ovl_e1");
        step_exp(1'b1, 1'b0, "ovl_e2");
        step_exp(1'b0, 1'b0, "ovl_e3");
        step_exp(1'b1, 1'b1, "ovl_e4");
        step_exp(1'b1, 1'b0, "ovl_e5");
        step_exp(1'b0, 1'b0, "ovl_e6");
        step_exp(1'b1, 1'b1, "ovl_e7");

        // Leading ones: 111101 -> one pulse after edge 6.
        mid_reset("rst_c");
        step_exp(1'b1, 1'b0, "lead_e1");
        step_exp(1'b1, 1'b0, "lead_e2");
        step_exp(1'b1, 1'b0, "lead_e3");
        step_exp(1'b1, 1'b0, "lead_e4");
        step_exp(1'b0, 1'b0, "lead_e5");
        step_exp(1'b1, 1'b1, "lead_e6");

        // Near miss: 1100101 never detects.
        mid_reset("rst_d");
        step_exp(1'b1, 1'b0, "miss_e1");
        step_exp(1'b1, 1'b0, "miss_e2");
        step_exp(1'b0, 1'b0, "miss_e3");
        step_exp(1'b0, 1'b0, "miss_e4");
        step_exp(1'b1, 1'b0, "miss_e5");
        step_exp(1'b0, 1'b0, "miss_e6");
        step_exp(1'b1, 1'b0, "miss_e7");

        // Reset mid-sequence discards "110".
        mid_reset("rst_e");
        step_exp(1'b1, 1'b0, "mid_e1");
        step_exp(1'b1, 1'b0, "mid_e2");
        step_exp(1'b0, 1'b0, "mid_e3");
        mid_reset("rst_mid");
        step_exp(1'b1, 1'b0, "mid_after1");
        step_exp(1'b1, 1'b0, "mid_post1");
        step_exp(1'b1, 1'b0, "mid_post2");
        step_exp(1'b0, 1'b0, "mid_post3");
        step_exp(1'b1, 1'b1, "mid_post4");

        // Reset while y is high drops y without a clock edge.
        #2 reset = 1'b1;
        #1 chk("rst_in_detect", y, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        #1;

        // Random bits with occasional asynchronous reset pulses.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) mid_reset("rnd_rst");
            else step(1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
